count_sequence_checker: RTL and testbench

Downstream monitor for the 3-bit synchronous up counter. It samples the counter's q output and checks that every sampled value is the previous value plus one, modulo 2^WIDTH. It counts wrap-arounds (7→0) and reports sequence errors as a pulse, a sticky flag and a saturating count. It latches a fault state after repeated consecutive errors.

---
 rtl/count_sequence_checker.sv | 112 +++++++++++
 tb/tb_count_sequence_checker.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequence_checker.sv
// Monitors an up-counter's output: every sample must be the previous one plus one.
// Reports wraps, sequence errors and latches a fault after ERR_LIMIT consecutive errors.
module count_sequence_checker #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned WRAP_W    = 8,
  parameter int unsigned ERR_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  q_in,
  input  logic              sample_en,
  input  logic              clear,
  output logic              locked,
  output logic              fault,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              seq_err,
  output logic              err_sticky,
  output logic [3:0]        err_count
);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  localparam logic [4:0] LIMIT = 5'(ERR_LIMIT);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  prev, prev_nxt, exp_val;
  logic [3:0]        miss, miss_nxt;
  logic              wrap_pulse_nxt, seq_err_nxt, err_sticky_nxt;
  logic [WRAP_W-1:0] wrap_count_nxt;
  logic [3:0]        err_count_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ACQUIRE;
      prev       <= '0;
      miss       <= '0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      seq_err    <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_nxt;
      prev       <= prev_nxt;
      miss       <= miss_nxt;
      wrap_pulse <= wrap_pulse_nxt;
      wrap_count <= wrap_count_nxt;
      seq_err    <= seq_err_nxt;
      err_sticky <= err_sticky_nxt;
      err_count  <= err_count_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    prev_nxt       = prev;
    miss_nxt       = miss;
    wrap_pulse_nxt = 1'b0;
    wrap_count_nxt = wrap_count;
    seq_err_nxt    = 1'b0;
    err_sticky_nxt = err_sticky;
    err_count_nxt  = err_count;
    exp_val        = prev + WIDTH'(1);

    if (clear) begin
      state_nxt      = ACQUIRE;
      prev_nxt       = '0;
      miss_nxt       = '0;
      wrap_count_nxt = '0;
      err_sticky_nxt = 1'b0;
      err_count_nxt  = '0;
    end else if (sample_en) begin
      unique case (state)
        ACQUIRE: begin
          prev_nxt  = q_in;
          miss_nxt  = '0;
          state_nxt = TRACK;
        end
        TRACK: begin
          // prev always follows q_in so a single glitch resynchronises checking
          prev_nxt = q_in;
          if (q_in == exp_val) begin
            miss_nxt = '0;
            if (prev == '1) begin
              wrap_pulse_nxt = 1'b1;
              wrap_count_nxt = wrap_count + WRAP_W'(1);
            end
          end else begin
            seq_err_nxt    = 1'b1;
            err_sticky_nxt = 1'b1;
            if (err_count != '1)
              err_count_nxt = err_count + 4'd1;
            miss_nxt = miss + 4'd1;
            if ({1'b0, miss} + 5'd1 == LIMIT)
              state_nxt = FAULT;
          end
        end
        FAULT: ;
        default: state_nxt = ACQUIRE;
      endcase
    end
  end

  assign locked = (state == TRACK);
  assign fault  = (state == FAULT);

endmodule

// File: tb/tb_count_sequence_checker.sv
// Randomised and directed bench for count_sequence_checker; two instances
// (ERR_LIMIT 2 and 15) share stimulus and are each checked against a behavioural model.
module tb_count_sequence_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] q_in = '0;
  logic       sample_en = 1'b0;
  logic       clear = 1'b0;

  logic       locked0, fault0, wp0, se0, sticky0;
  logic [7:0] wc0;
  logic [3:0] ec0;
  logic       locked1, fault1, wp1, se1, sticky1;
  logic [7:0] wc1;
  logic [3:0] ec1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  count_sequence_checker #(.WIDTH(3), .WRAP_W(8), .ERR_LIMIT(2)) dut2 (
    .clk(clk), .rst(rst), .q_in(q_in), .sample_en(sample_en), .clear(clear),
    .locked(locked0), .fault(fault0), .wrap_pulse(wp0), .wrap_count(wc0),
    .seq_err(se0), .err_sticky(sticky0), .err_count(ec0));

  count_sequence_checker #(.WIDTH(3), .WRAP_W(8), .ERR_LIMIT(15)) dut15 (
    .clk(clk), .rst(rst), .q_in(q_in), .sample_en(sample_en), .clear(clear),
    .locked(locked1), .fault(fault1), .wrap_pulse(wp1), .wrap_count(wc1),
    .seq_err(se1), .err_sticky(sticky1), .err_count(ec1));

  // Behavioural model: mode 0=acquiring, 1=tracking, 2=faulted; totals kept unbounded
  int m_mode[2], m_prev[2], m_miss[2], m_wraps[2], m_errs[2];
  bit m_sticky[2], m_wp[2], m_se[2];
  int lim[2] = '{2, 15};

  function automatic void model_reset(int k);
    m_mode[k] = 0; m_prev[k] = 0; m_miss[k] = 0; m_wraps[k] = 0; m_errs[k] = 0;
    m_sticky[k] = 0; m_wp[k] = 0; m_se[k] = 0;
  endfunction

  function automatic void model_step(int k, int q, bit en, bit clr);
    m_wp[k] = 0;
    m_se[k] = 0;
    if (clr) begin
      model_reset(k);
    end else if (en) begin
      if (m_mode[k] == 0) begin
        m_prev[k] = q; m_miss[k] = 0; m_mode[k] = 1;
      end else if (m_mode[k] == 1) begin
        if (q == (m_prev[k] + 1) % 8) begin
          if (m_prev[k] == 7) begin m_wp[k] = 1; m_wraps[k]++; end
          m_miss[k] = 0;
        end else begin
          m_se[k] = 1; m_sticky[k] = 1; m_errs[k]++; m_miss[k]++;
          if (m_miss[k] == lim[k]) m_mode[k] = 2;
        end
        m_prev[k] = q;
      end
    end
  endfunction

  function automatic logic [16:0] exp_vec(int k);
    int ec;
    ec = (m_errs[k] > 15) ? 15 : m_errs[k];
    return {m_mode[k] == 1, m_mode[k] == 2, m_wp[k], 8'(m_wraps[k] % 256),
            m_se[k], m_sticky[k], 4'(ec)};
  endfunction

  function automatic logic [16:0] act_vec(int k);
    if (k == 0) return {locked0, fault0, wp0, wc0, se0, sticky0, ec0};
    return {locked1, fault1, wp1, wc1, se1, sticky1, ec1};
  endfunction

  task automatic drive(int q, bit en, bit clr);
    q_in = 3'(q); sample_en = en; clear = clr;
    @(posedge clk);
    model_step(0, q, en, clr);
    model_step(1, q, en, clr);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset(0); model_reset(1);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_vec(k) !== 17'd0) begin
        failures++;
        $display("FAIL reset_state dut%0d got=%h exp=%h", k, act_vec(k), 17'd0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_count_sequence();
    int pulses = 0;
    int errs = 0;
    for (int i = 0; i < 10; i++) begin
      drive(i % 8, 1'b1, 1'b0);
      pulses += wp0;
      errs += se0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL count_seq step%0d dut%0d got=%h exp=%h", i, k, act_vec(k), exp_vec(k));
        end
      end
    end
    checks++;
    if (pulses != 1 || errs != 0 || wc0 !== 8'd1 || locked0 !== 1'b1) begin
      failures++;
      $display("FAIL count_seq_summary got pulses=%0d errs=%0d wc=%0d locked=%b exp 1 0 1 1",
               pulses, errs, wc0, locked0);
    end
  endtask

  task automatic test_full_wraps();
    int pulses = 0;
    drive(0, 1'b0, 1'b1);
    drive(0, 1'b1, 1'b0);
    for (int i = 1; i <= 2048; i++) begin
      drive(i % 8, 1'b1, 1'b0);
      pulses += wp1;
      if (i % 256 == 0) begin
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (act_vec(k) !== exp_vec(k)) begin
            failures++;
            $display("FAIL full_wraps i%0d dut%0d got=%h exp=%h", i, k, act_vec(k), exp_vec(k));
          end
        end
      end
    end
    checks++;
    if (pulses != 256 || wc1 !== 8'd0) begin
      failures++;
      $display("FAIL full_wraps_total got pulses=%0d wc=%0d exp pulses=256 wc=0", pulses, wc1);
    end
  endtask

  task automatic test_resync();
    int seq[4] = '{2, 3, 5, 6};
    int errs = 0;
    drive(0, 1'b0, 1'b1);
    foreach (seq[i]) begin
      drive(seq[i], 1'b1, 1'b0);
      errs += se0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL resync step%0d dut%0d got=%h exp=%h", i, k, act_vec(k), exp_vec(k));
        end
      end
    end
    checks++;
    if (errs != 1 || ec0 !== 4'd1 || sticky0 !== 1'b1 || locked0 !== 1'b1) begin
      failures++;
      $display("FAIL resync_summary got errs=%0d ec=%0d sticky=%b locked=%b exp 1 1 1 1",
               errs, ec0, sticky0, locked0);
    end
  endtask

  task automatic test_fault();
    int seq[5] = '{2, 2, 2, 3, 4};
    int errs = 0;
    drive(0, 1'b0, 1'b1);
    foreach (seq[i]) begin
      drive(seq[i], 1'b1, 1'b0);
      errs += se0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL fault step%0d dut%0d got=%h exp=%h", i, k, act_vec(k), exp_vec(k));
        end
      end
    end
    checks++;
    if (errs != 2 || fault0 !== 1'b1 || locked0 !== 1'b0 || ec0 !== 4'd2) begin
      failures++;
      $display("FAIL fault_summary got errs=%0d fault=%b locked=%b ec=%0d exp 2 1 0 2",
               errs, fault0, locked0, ec0);
    end
  endtask

  task automatic test_saturation();
    int p = 0;
    drive(0, 1'b0, 1'b1);
    drive(0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      p = (p + 3) % 8;
      drive(p, 1'b1, 1'b0);
      p = (p + 1) % 8;
      drive(p, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL saturate i%0d dut%0d got=%h exp=%h", i, k, act_vec(k), exp_vec(k));
        end
      end
    end
    checks++;
    if (ec1 !== 4'd15 || ec0 !== 4'd15) begin
      failures++;
      $display("FAIL saturate_count got=%0d/%0d exp=15", ec0, ec1);
    end
    drive(5, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_vec(k) !== 17'd0) begin
        failures++;
        $display("FAIL clear_wins dut%0d got=%h exp=%h", k, act_vec(k), 17'd0);
      end
    end
    drive(7, 1'b1, 1'b0);
    checks++;
    if (locked1 !== 1'b1 || se1 !== 1'b0 || act_vec(1) !== exp_vec(1)) begin
      failures++;
      $display("FAIL clear_then_acquire got=%h exp=%h", act_vec(1), exp_vec(1));
    end
  endtask

  task automatic test_async_reset();
    drive(0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b0);
    drive(7, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    model_reset(0); model_reset(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_vec(k) !== 17'd0) begin
        failures++;
        $display("FAIL async_reset dut%0d got=%h exp=%h", k, act_vec(k), 17'd0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    drive(4, 1'b1, 1'b0);
    checks++;
    if (locked0 !== 1'b1 || se0 !== 1'b0 || wp0 !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_acquire got locked=%b se=%b wp=%b exp 1 0 0", locked0, se0, wp0);
    end
    drive(5, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_vec(k) !== exp_vec(k)) begin
        failures++;
        $display("FAIL post_reset_track dut%0d got=%h exp=%h", k, act_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_random();
    int q;
    bit en, clr;
    drive(0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 9) < 7) q = (m_prev[1] + 1) % 8;
      else q = $urandom_range(0, 7);
      drive(q, en, clr);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL random i%0d dut%0d got=%h exp=%h", i, k, act_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_sequence();
    test_full_wraps();
    test_resync();
    test_fault();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
